// File: rtl/engine_cmd_rx.sv
// engine_cmd_rx: collects NUM_WORDS broadcast words into a frame and hands it to the engine core
// with a one-cycle op_start. rtr is held low from launch until the core reports op_done.
module engine_cmd_rx #(
  parameter int ENGINE_ID = 0,
  parameter int NUM_WORDS = 5,
  localparam int IW = $clog2(NUM_WORDS) + 1
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    engine_in_rts,
  output logic                    engine_out_rtr,
  input  logic [15:0]             bcast_in_data,
  input  logic                    flush,
  input  logic                    op_done,
  output logic                    op_start,
  output logic [16*NUM_WORDS-1:0] params_out,
  output logic [IW-1:0]           word_idx,
  output logic [7:0]              frame_cnt
);
  if (ENGINE_ID < 0 || ENGINE_ID > 4 || NUM_WORDS < 1 || NUM_WORDS > 16) begin : g_bad_cfg
    $error("engine_cmd_rx: ENGINE_ID must be 0..4 and NUM_WORDS 1..16");
  end

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_LAUNCH, S_BUSY} state_t;

  state_t                    r_state;
  state_t                    w_nxt;
  logic                      r_rtr;
  logic [IW-1:0]             r_idx;
  logic [7:0]                r_cnt;
  logic [16*NUM_WORDS-1:0]   r_shadow;
  logic [16*NUM_WORDS-1:0]   r_params;
  logic [16*NUM_WORDS-1:0]   w_frame;
  logic                      w_take;
  logic                      w_last;

  // rtr is only high in IDLE/COLLECT, so it alone qualifies a transfer; flush drops the word
  assign w_take = engine_in_rts && r_rtr && !flush;
  assign w_last = r_idx == IW'(NUM_WORDS - 1);

  always_comb begin
    w_nxt = (r_state == S_LAUNCH) ? S_BUSY :
            (r_state == S_BUSY)   ? (op_done ? S_IDLE : S_BUSY) :
            flush                 ? S_IDLE :
            w_take                ? (w_last ? S_LAUNCH : S_COLLECT) : r_state;
  end

  // The launching frame is the shadow with the word arriving this cycle merged in
  always_comb begin
    w_frame = r_shadow;
    for (int k = 0; k < NUM_WORDS; k++)
      if (r_idx == IW'(k)) w_frame[16*k +: 16] = bcast_in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_rtr    <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_params <= '0;
    end else begin
      r_rtr <= (w_nxt == S_IDLE) || (w_nxt == S_COLLECT);
      r_idx <= (w_nxt != S_COLLECT) ? '0 : w_take ? r_idx + IW'(1) : r_idx;
      if (w_take) r_shadow <= w_frame;
      if (w_take && w_last) begin
        r_params <= w_frame;
        r_cnt    <= r_cnt + 8'd1;
      end
    end
  end

  assign engine_out_rtr = r_rtr;
  assign op_start       = r_state == S_LAUNCH;
  assign params_out     = r_params;
  assign word_idx       = r_idx;
  assign frame_cnt      = r_cnt;
endmodule
